// File: rtl/bp_cce_mmio_cfg_endpoint_pkg.sv
// Types private to the cfg endpoint.
package bp_cce_mmio_cfg_endpoint_pkg;

    typedef enum logic [1:0] {
        e_ready      = 2'd0,
        e_ucode_wait = 2'd1,
        e_resp       = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/bp_common_cfg_link_pkg.sv
// Local (tile-internal) address map of the cfg device: address layout, device id, register offsets.
package bp_common_cfg_link_pkg;

    typedef struct packed {
        logic [15:0] nonlocal;
        logic [3:0]  cce;
        logic [3:0]  dev;
        logic [15:0] addr;
    } bp_local_addr_s;

    localparam logic [3:0]  cfg_dev_gp = 4'h2;

    localparam logic [15:0] bp_cfg_reg_reset_gp          = 16'h0001;
    localparam logic [15:0] bp_cfg_reg_freeze_gp         = 16'h0002;
    localparam logic [15:0] bp_cfg_reg_npc_gp            = 16'h0010;
    localparam logic [15:0] bp_cfg_reg_icache_mode_gp    = 16'h0022;
    localparam logic [15:0] bp_cfg_reg_dcache_mode_gp    = 16'h0043;
    localparam logic [15:0] bp_cfg_reg_cce_mode_gp       = 16'h0081;
    localparam logic [15:0] bp_cfg_mem_base_cce_ucode_gp = 16'h8000;

endpackage

// File: rtl/bp_common_pkg.sv
// Common io message encodings and cache/CCE mode values shared across the tile.
package bp_common_pkg;

    localparam int io_msg_type_width_gp = 4;
    localparam int io_msg_size_width_gp = 3;

    typedef enum logic [3:0] {
        e_cce_io_rd = 4'b0000,
        e_cce_io_wr = 4'b0001
    } bp_cce_io_type_e;

    typedef enum logic [2:0] {
        e_io_size_1 = 3'b000,
        e_io_size_2 = 3'b001,
        e_io_size_4 = 3'b010,
        e_io_size_8 = 3'b011
    } bp_io_size_e;

    typedef enum logic {
        e_lce_mode_uncached = 1'b0,
        e_lce_mode_normal   = 1'b1
    } bp_lce_mode_e;

    typedef enum logic {
        e_cce_mode_uncached = 1'b0,
        e_cce_mode_normal   = 1'b1
    } bp_cce_mode_e;

endpackage

// File: rtl/bp_cce_mmio_cfg_reg_file.sv
// Tile config registers with combinational read mux; writes commit on the edge w_v_i is high.
// Zero latency read, no backpressure; unmapped addresses read zero and ignore writes.
module bp_cce_mmio_cfg_reg_file
    import bp_common_pkg::*;
    import bp_common_cfg_link_pkg::*;
#(
    parameter int cfg_addr_width_p = 16,
    parameter int dword_width_p    = 64,
    parameter int vaddr_width_p    = 39
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        w_v_i,
    input  logic [cfg_addr_width_p-1:0] addr_i,
    input  logic [vaddr_width_p-1:0]    data_i,
    output logic [dword_width_p-1:0]    data_o,
    output logic                        reset_o,
    output logic                        freeze_o,
    output logic                        icache_mode_o,
    output logic                        dcache_mode_o,
    output logic                        cce_mode_o,
    output logic [vaddr_width_p-1:0]    npc_o,
    output logic                        npc_w_v_o
);

    logic reset_li;
    logic w_reset, w_freeze, w_icache, w_dcache, w_cce, w_npc;

    assign reset_li = ~reset_n_i;
    assign w_reset  = w_v_i & (addr_i == bp_cfg_reg_reset_gp);
    assign w_freeze = w_v_i & (addr_i == bp_cfg_reg_freeze_gp);
    assign w_icache = w_v_i & (addr_i == bp_cfg_reg_icache_mode_gp);
    assign w_dcache = w_v_i & (addr_i == bp_cfg_reg_dcache_mode_gp);
    assign w_cce    = w_v_i & (addr_i == bp_cfg_reg_cce_mode_gp);
    assign w_npc    = w_v_i & (addr_i == bp_cfg_reg_npc_gp);
    assign npc_w_v_o = w_npc;

    // Tile comes out of reset held in reset and frozen until software releases it.
    bsg_dff_reset_en #(.width_p(1), .reset_val_p(1'b1)) reset_reg (
        .clk_i(clk_i), .reset_i(reset_li), .en_i(w_reset), .data_i(data_i[0]), .data_o(reset_o)
    );
    bsg_dff_reset_en #(.width_p(1), .reset_val_p(1'b1)) freeze_reg (
        .clk_i(clk_i), .reset_i(reset_li), .en_i(w_freeze), .data_i(data_i[0]), .data_o(freeze_o)
    );
    bsg_dff_reset_en #(.width_p(1), .reset_val_p(e_lce_mode_uncached)) icache_mode_reg (
        .clk_i(clk_i), .reset_i(reset_li), .en_i(w_icache), .data_i(data_i[0]), .data_o(icache_mode_o)
    );
    bsg_dff_reset_en #(.width_p(1), .reset_val_p(e_lce_mode_uncached)) dcache_mode_reg (
        .clk_i(clk_i), .reset_i(reset_li), .en_i(w_dcache), .data_i(data_i[0]), .data_o(dcache_mode_o)
    );
    bsg_dff_reset_en #(.width_p(1), .reset_val_p(e_cce_mode_uncached)) cce_mode_reg (
        .clk_i(clk_i), .reset_i(reset_li), .en_i(w_cce), .data_i(data_i[0]), .data_o(cce_mode_o)
    );
    bsg_dff_reset_en #(.width_p(vaddr_width_p), .reset_val_p('0)) npc_reg (
        .clk_i(clk_i), .reset_i(reset_li), .en_i(w_npc), .data_i(data_i), .data_o(npc_o)
    );

    always_comb begin
        data_o = '0;
        case (addr_i)
            bp_cfg_reg_reset_gp:       data_o[0] = reset_o;
            bp_cfg_reg_freeze_gp:      data_o[0] = freeze_o;
            bp_cfg_reg_icache_mode_gp: data_o[0] = icache_mode_o;
            bp_cfg_reg_dcache_mode_gp: data_o[0] = dcache_mode_o;
            bp_cfg_reg_cce_mode_gp:    data_o[0] = cce_mode_o;
            bp_cfg_reg_npc_gp:         data_o[vaddr_width_p-1:0] = npc_o;
            default:                   data_o = '0;
        endcase
    end

endmodule

// File: rtl/bsg_dff_reset_en.sv
// Enabled flop with synchronous active-high reset to a parameterised value.
module bsg_dff_reset_en #(
    parameter int                 width_p     = 1,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_o <= reset_val_p;
        end else if (en_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/bp_cce_mmio_cfg_endpoint.sv
// Cfg-network endpoint: decodes io_cmd, writes tile config regs / CCE ucode RAM, returns one io_resp each.
// Response 1 cycle after accept (2 for ucode reads); one command in flight, holds response until ready.
module bp_cce_mmio_cfg_endpoint
    import bp_common_pkg::*;
    import bp_common_cfg_link_pkg::*;
    import bp_cce_mmio_cfg_endpoint_pkg::*;
#(
    parameter int paddr_width_p         = 40,
    parameter int dword_width_p         = 64,
    parameter int lce_id_width_p        = 4,
    parameter int cfg_addr_width_p      = 16,
    parameter int cce_id_width_p        = 4,
    parameter int inst_ram_addr_width_p = 8,
    parameter int inst_width_p          = 48,
    parameter int vaddr_width_p         = 39,
    localparam int cce_io_msg_width_lp  = io_msg_type_width_gp + io_msg_size_width_gp
                                          + lce_id_width_p + paddr_width_p + dword_width_p
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [cce_id_width_p-1:0]        cce_id_i,
    input  logic [cce_io_msg_width_lp-1:0]   io_cmd_i,
    input  logic                             io_cmd_v_i,
    output logic                             io_cmd_yumi_o,
    output logic [cce_io_msg_width_lp-1:0]   io_resp_o,
    output logic                             io_resp_v_o,
    input  logic                             io_resp_ready_i,
    output logic                             reset_o,
    output logic                             freeze_o,
    output logic                             icache_mode_o,
    output logic                             dcache_mode_o,
    output logic                             cce_mode_o,
    output logic [vaddr_width_p-1:0]         npc_o,
    output logic                             npc_w_v_o,
    output logic                             ucode_w_v_o,
    output logic                             ucode_r_v_o,
    output logic [inst_ram_addr_width_p-1:0] ucode_addr_o,
    output logic [inst_width_p-1:0]          ucode_data_o,
    input  logic [inst_width_p-1:0]          ucode_data_i
);

    localparam int addr_lsb_lp    = dword_width_p;
    localparam int payload_lsb_lp = addr_lsb_lp + paddr_width_p;
    localparam int size_lsb_lp    = payload_lsb_lp + lce_id_width_p;
    localparam int type_lsb_lp    = size_lsb_lp + io_msg_size_width_gp;

    logic [dword_width_p-1:0]         cmd_data;
    logic [paddr_width_p-1:0]         cmd_addr;
    logic [lce_id_width_p-1:0]        cmd_payload;
    logic [io_msg_size_width_gp-1:0]  cmd_size;
    logic [io_msg_type_width_gp-1:0]  cmd_type;
    bp_local_addr_s                   local_addr;

    assign cmd_data    = io_cmd_i[dword_width_p-1:0];
    assign cmd_addr    = io_cmd_i[addr_lsb_lp +: paddr_width_p];
    assign cmd_payload = io_cmd_i[payload_lsb_lp +: lce_id_width_p];
    assign cmd_size    = io_cmd_i[size_lsb_lp +: io_msg_size_width_gp];
    assign cmd_type    = io_cmd_i[type_lsb_lp +: io_msg_type_width_gp];
    assign local_addr  = cmd_addr;

    // Only the low instruction-width bits of the write data are meaningful to any target.
    logic unused_cmd_data_hi;
    assign unused_cmd_data_hi = ^cmd_data[dword_width_p-1:inst_width_p];

    logic hit, ucode_sel, is_wr, is_rd, reg_w_v;
    assign hit       = ~|local_addr.nonlocal & (local_addr.cce == cce_id_i) & (local_addr.dev == cfg_dev_gp);
    assign ucode_sel = local_addr.addr[cfg_addr_width_p-1:inst_ram_addr_width_p]
                       == bp_cfg_mem_base_cce_ucode_gp[cfg_addr_width_p-1:inst_ram_addr_width_p];
    assign is_wr     = (cmd_type == e_cce_io_wr);
    assign is_rd     = (cmd_type == e_cce_io_rd);

    assign ucode_addr_o = local_addr.addr[inst_ram_addr_width_p-1:0];
    assign ucode_data_o = cmd_data[inst_width_p-1:0];

    logic [dword_width_p-1:0] rf_data;

    bp_cce_mmio_cfg_reg_file #(
        .cfg_addr_width_p(cfg_addr_width_p),
        .dword_width_p   (dword_width_p),
        .vaddr_width_p   (vaddr_width_p)
    ) reg_file (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .w_v_i        (reg_w_v),
        .addr_i       (local_addr.addr),
        .data_i       (cmd_data[vaddr_width_p-1:0]),
        .data_o       (rf_data),
        .reset_o      (reset_o),
        .freeze_o     (freeze_o),
        .icache_mode_o(icache_mode_o),
        .dcache_mode_o(dcache_mode_o),
        .cce_mode_o   (cce_mode_o),
        .npc_o        (npc_o),
        .npc_w_v_o    (npc_w_v_o)
    );

    cfg_state_e state_r, state_n;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= e_ready;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_ready:      if (io_cmd_yumi_o) state_n = ucode_r_v_o ? e_ucode_wait : e_resp;
            e_ucode_wait: state_n = e_resp;
            e_resp:       if (io_resp_ready_i) state_n = e_ready;
            default:      state_n = e_ready;
        endcase
    end

    // Reset gates acceptance so no strobe or register write can fire while reset is held.
    always_comb begin
        io_cmd_yumi_o = 1'b0;
        io_resp_v_o   = 1'b0;
        case (state_r)
            e_ready: io_cmd_yumi_o = io_cmd_v_i & reset_n_i;
            e_resp:  io_resp_v_o   = 1'b1;
            default: ;
        endcase
        reg_w_v     = io_cmd_yumi_o & hit & ~ucode_sel & is_wr;
        ucode_w_v_o = io_cmd_yumi_o & hit & ucode_sel & is_wr;
        ucode_r_v_o = io_cmd_yumi_o & hit & ucode_sel & is_rd;
    end

    logic [io_msg_type_width_gp-1:0] resp_type_r;
    logic [io_msg_size_width_gp-1:0] resp_size_r;
    logic [lce_id_width_p-1:0]       resp_payload_r;
    logic [paddr_width_p-1:0]        resp_addr_r;
    logic [dword_width_p-1:0]        resp_data_r;

    always_ff @(posedge clk_i) begin
        if (io_cmd_yumi_o) begin
            resp_type_r    <= cmd_type;
            resp_size_r    <= cmd_size;
            resp_payload_r <= cmd_payload;
            resp_addr_r    <= cmd_addr;
            resp_data_r    <= (hit & is_rd & ~ucode_sel) ? rf_data : '0;
        end else if (state_r == e_ucode_wait) begin
            resp_data_r    <= {{(dword_width_p-inst_width_p){1'b0}}, ucode_data_i};
        end
    end

    assign io_resp_o = {resp_type_r, resp_size_r, resp_payload_r, resp_addr_r, resp_data_r};

endmodule

// File: tb/tb_bp_cce_mmio_cfg_endpoint.sv
// Directed bench for the cfg endpoint with a response scoreboard and a register/ucode reference model.
module tb_bp_cce_mmio_cfg_endpoint;
    import bp_common_pkg::*;
    import bp_common_cfg_link_pkg::*;

    localparam int paddr_w = 40, dword_w = 64, lce_w = 4, cfg_w = 16, cce_w = 4;
    localparam int ram_w = 8, inst_w = 48, vaddr_w = 39;
    localparam int msg_w = 4 + 3 + lce_w + paddr_w + dword_w;
    localparam logic [cce_w-1:0] my_cce = 4'h3;

    typedef logic [msg_w-1:0] msg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n_i;
    logic [cce_w-1:0]   cce_id_i;
    msg_t               io_cmd_i;
    logic               io_cmd_v_i;
    logic               io_cmd_yumi_o;
    msg_t               io_resp_o;
    logic               io_resp_v_o;
    logic               io_resp_ready_i;
    logic               reset_o, freeze_o, icache_mode_o, dcache_mode_o, cce_mode_o;
    logic [vaddr_w-1:0] npc_o;
    logic               npc_w_v_o, ucode_w_v_o, ucode_r_v_o;
    logic [ram_w-1:0]   ucode_addr_o;
    logic [inst_w-1:0]  ucode_data_o;
    logic [inst_w-1:0]  ucode_data_i;

    bp_cce_mmio_cfg_endpoint dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .cce_id_i(cce_id_i),
        .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_yumi_o(io_cmd_yumi_o),
        .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_ready_i(io_resp_ready_i),
        .reset_o(reset_o), .freeze_o(freeze_o), .icache_mode_o(icache_mode_o),
        .dcache_mode_o(dcache_mode_o), .cce_mode_o(cce_mode_o), .npc_o(npc_o),
        .npc_w_v_o(npc_w_v_o), .ucode_w_v_o(ucode_w_v_o), .ucode_r_v_o(ucode_r_v_o),
        .ucode_addr_o(ucode_addr_o), .ucode_data_o(ucode_data_o), .ucode_data_i(ucode_data_i)
    );

    // Microcode RAM attached to the endpoint: synchronous read, data one cycle after the strobe.
    logic [inst_w-1:0] tb_ram [256];
    always @(posedge clk) begin
        if (ucode_w_v_o) tb_ram[ucode_addr_o] <= ucode_data_o;
        if (ucode_r_v_o) ucode_data_i <= tb_ram[ucode_addr_o];
    end

    int vectors = 0;
    int miscompares = 0;
    msg_t exp_q[$];

    logic               m_reset, m_freeze, m_ic, m_dc, m_cm;
    logic [vaddr_w-1:0] m_npc;
    logic [inst_w-1:0]  m_ucode [256];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic msg_t mk_msg(input logic [3:0] typ, input logic [3:0] pay,
                                    input logic [paddr_w-1:0] ad, input logic [dword_w-1:0] d);
        return {typ, e_io_size_8, pay, ad, d};
    endfunction

    function automatic logic [paddr_w-1:0] mk_addr(input logic [cce_w-1:0] cce, input logic [cfg_w-1:0] a);
        return {16'h0000, cce, cfg_dev_gp, a};
    endfunction

    task automatic reset_model();
        m_reset = 1'b1; m_freeze = 1'b1; m_ic = 1'b0; m_dc = 1'b0; m_cm = 1'b0; m_npc = '0;
    endtask

    function automatic logic [dword_w-1:0] model_read(input logic [cce_w-1:0] cce, input logic [cfg_w-1:0] a);
        logic [dword_w-1:0] r;
        r = '0;
        if (cce == my_cce) begin
            if (a[15:8] == bp_cfg_mem_base_cce_ucode_gp[15:8]) r = {16'h0, m_ucode[a[7:0]]};
            else if (a == bp_cfg_reg_reset_gp)       r[0] = m_reset;
            else if (a == bp_cfg_reg_freeze_gp)      r[0] = m_freeze;
            else if (a == bp_cfg_reg_icache_mode_gp) r[0] = m_ic;
            else if (a == bp_cfg_reg_dcache_mode_gp) r[0] = m_dc;
            else if (a == bp_cfg_reg_cce_mode_gp)    r[0] = m_cm;
            else if (a == bp_cfg_reg_npc_gp)         r[vaddr_w-1:0] = m_npc;
        end
        return r;
    endfunction

    task automatic model_write(input logic [cce_w-1:0] cce, input logic [cfg_w-1:0] a, input logic [dword_w-1:0] d);
        if (cce == my_cce) begin
            if (a[15:8] == bp_cfg_mem_base_cce_ucode_gp[15:8]) m_ucode[a[7:0]] = d[inst_w-1:0];
            else if (a == bp_cfg_reg_reset_gp)       m_reset  = d[0];
            else if (a == bp_cfg_reg_freeze_gp)      m_freeze = d[0];
            else if (a == bp_cfg_reg_icache_mode_gp) m_ic     = d[0];
            else if (a == bp_cfg_reg_dcache_mode_gp) m_dc     = d[0];
            else if (a == bp_cfg_reg_cce_mode_gp)    m_cm     = d[0];
            else if (a == bp_cfg_reg_npc_gp)         m_npc    = d[vaddr_w-1:0];
        end
    endtask

    task automatic check_regs(input string where);
        chk({where, "_reset_o"}, reset_o, m_reset);
        chk({where, "_freeze_o"}, freeze_o, m_freeze);
        chk({where, "_icache_mode"}, icache_mode_o, m_ic);
        chk({where, "_dcache_mode"}, dcache_mode_o, m_dc);
        chk({where, "_cce_mode"}, cce_mode_o, m_cm);
        chk({where, "_npc"}, npc_o, m_npc);
    endtask

    task automatic check_resp();
        msg_t e;
        chk("sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("resp_msg", io_resp_o, e);
        end
    endtask

    // Pushes the expected response at drive time, then checks accept strobes, latency and response.
    task automatic send(input logic [3:0] typ, input logic [cce_w-1:0] cce, input logic [cfg_w-1:0] a,
                        input logic [dword_w-1:0] d, input logic [3:0] pay, input int exp_lat);
        logic is_hit, is_uc, is_wr, is_rd;
        logic [dword_w-1:0] rd;
        int n, lat;
        is_hit = (cce == my_cce);
        is_uc  = (a[15:8] == bp_cfg_mem_base_cce_ucode_gp[15:8]);
        is_wr  = (typ == e_cce_io_wr);
        is_rd  = (typ == e_cce_io_rd);
        rd = model_read(cce, a);
        exp_q.push_back(mk_msg(typ, pay, mk_addr(cce, a), is_rd ? rd : '0));
        if (is_wr) model_write(cce, a, d);
        io_cmd_i = mk_msg(typ, pay, mk_addr(cce, a), d);
        io_cmd_v_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!io_cmd_yumi_o && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk("accept", io_cmd_yumi_o, 1'b1);
        chk("ucode_w_v", ucode_w_v_o, is_hit & is_uc & is_wr);
        chk("ucode_r_v", ucode_r_v_o, is_hit & is_uc & is_rd);
        chk("npc_w_v", npc_w_v_o, is_hit & is_wr & (a == bp_cfg_reg_npc_gp));
        if (is_hit && is_uc) chk("ucode_addr", ucode_addr_o, a[7:0]);
        if (is_hit && is_uc && is_wr) chk("ucode_data", ucode_data_o, d[inst_w-1:0]);
        tick();
        io_cmd_v_i = 1'b0;
        check_regs("post_accept");
        lat = 1;
        @(negedge clk);
        while (!io_resp_v_o && lat < 20) begin
            tick();
            @(negedge clk);
            lat++;
        end
        chk("resp_latency", lat, exp_lat);
        chk("npc_w_v_single", npc_w_v_o, 1'b0);
        if (io_resp_v_o && io_resp_ready_i) check_resp();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i = 1'b0; io_cmd_v_i = 1'b0; io_cmd_i = '0; io_resp_ready_i = 1'b1; cce_id_i = my_cce;
        reset_model();
        repeat (3) tick();
        @(negedge clk);
        check_regs("in_reset");
        chk("in_reset_resp_v", io_resp_v_o, 1'b0);
        chk("in_reset_ucode_w", ucode_w_v_o, 1'b0);
        tick();
        reset_n_i = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check_regs("idle");
        chk("idle_resp_v", io_resp_v_o, 1'b0);
        chk("idle_yumi", io_cmd_yumi_o, 1'b0);
        tick();

        send(e_cce_io_wr, my_cce, bp_cfg_reg_reset_gp, 64'h0, 4'h1, 1);
        chk("reset_released", reset_o, 1'b0);
        send(e_cce_io_wr, my_cce, bp_cfg_reg_freeze_gp, 64'h0, 4'h2, 1);
        chk("freeze_released", freeze_o, 1'b0);

        send(e_cce_io_wr, my_cce, bp_cfg_reg_npc_gp, 64'h0000_0080_0000_0000 >> 8, 4'h3, 1);
        chk("npc_value", npc_o, 39'h00_8000_0000);
        send(e_cce_io_rd, my_cce, bp_cfg_reg_npc_gp, 64'h0, 4'h4, 1);

        send(e_cce_io_wr, my_cce, bp_cfg_mem_base_cce_ucode_gp | 16'h0005, 64'h0000_1234_5678_9ABC, 4'h5, 1);
        send(e_cce_io_rd, my_cce, bp_cfg_mem_base_cce_ucode_gp | 16'h0005, 64'h0, 4'h6, 2);

        send(e_cce_io_wr, my_cce, bp_cfg_reg_cce_mode_gp, 64'hFFFF_FFFF_FFFF_FFFF, 4'h7, 1);
        send(e_cce_io_rd, my_cce, bp_cfg_reg_cce_mode_gp, 64'h0, 4'h8, 1);
        send(e_cce_io_rd, my_cce, bp_cfg_reg_freeze_gp, 64'h0, 4'h9, 1);

        // Response held off with the next command already waiting.
        io_resp_ready_i = 1'b0;
        exp_q.push_back(mk_msg(e_cce_io_wr, 4'hA, mk_addr(my_cce, bp_cfg_reg_dcache_mode_gp), 64'h0));
        model_write(my_cce, bp_cfg_reg_dcache_mode_gp, 64'h1);
        io_cmd_i = mk_msg(e_cce_io_wr, 4'hA, mk_addr(my_cce, bp_cfg_reg_dcache_mode_gp), 64'h1);
        io_cmd_v_i = 1'b1;
        @(negedge clk);
        chk("stall_first_accept", io_cmd_yumi_o, 1'b1);
        tick();
        chk("stall_dcache_mode", dcache_mode_o, 1'b1);
        exp_q.push_back(mk_msg(e_cce_io_rd, 4'hB, mk_addr(my_cce, bp_cfg_reg_dcache_mode_gp),
                               model_read(my_cce, bp_cfg_reg_dcache_mode_gp)));
        io_cmd_i = mk_msg(e_cce_io_rd, 4'hB, mk_addr(my_cce, bp_cfg_reg_dcache_mode_gp), 64'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_yumi", io_cmd_yumi_o, 1'b0);
            chk("stall_resp_v", io_resp_v_o, 1'b1);
            chk("stall_resp_stable", io_resp_o, exp_q[0]);
            tick();
        end
        io_resp_ready_i = 1'b1;
        @(negedge clk);
        chk("release_resp_v", io_resp_v_o, 1'b1);
        check_resp();
        tick();
        @(negedge clk);
        chk("next_cmd_accept", io_cmd_yumi_o, 1'b1);
        tick();
        io_cmd_v_i = 1'b0;
        @(negedge clk);
        chk("next_resp_v", io_resp_v_o, 1'b1);
        check_resp();
        tick();

        send(e_cce_io_wr, 4'h7, bp_cfg_reg_icache_mode_gp, 64'h1, 4'hC, 1);
        chk("miss_icache_unchanged", icache_mode_o, 1'b0);
        send(e_cce_io_rd, my_cce, 16'h0FFF, 64'h0, 4'hD, 1);
        send(e_cce_io_rd, 4'h1, bp_cfg_reg_npc_gp, 64'h0, 4'hE, 1);

        // Reset asserted while a response is pending drops it.
        io_resp_ready_i = 1'b0;
        io_cmd_i = mk_msg(e_cce_io_wr, 4'hF, mk_addr(my_cce, bp_cfg_reg_icache_mode_gp), 64'h1);
        io_cmd_v_i = 1'b1;
        @(negedge clk);
        chk("rst_resp_accept", io_cmd_yumi_o, 1'b1);
        tick();
        io_cmd_v_i = 1'b0;
        @(negedge clk);
        chk("rst_resp_pending", io_resp_v_o, 1'b1);
        reset_n_i = 1'b0;
        tick();
        reset_model();
        @(negedge clk);
        chk("rst_resp_dropped", io_resp_v_o, 1'b0);
        check_regs("rst_in_resp");
        tick();
        reset_n_i = 1'b1;
        io_resp_ready_i = 1'b1;
        tick();
        send(e_cce_io_rd, my_cce, bp_cfg_reg_reset_gp, 64'h0, 4'h1, 1);

        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bp_cce_mmio_cfg_endpoint.md
Name: bp_cce_mmio_cfg_endpoint

Overview:
- Downstream consumer of the cfg-network command stream emitted by the MMIO config loader.
- Decodes each io_cmd addressed to this tile's cfg device and applies writes to the tile config registers (reset, freeze, cache modes, CCE mode, NPC) or to the CCE microcode RAM.
- Returns exactly one io_resp per command, carrying read data for reads and zero for writes.
- Holds one command in flight at a time.

Parameters:
- paddr_width_p, 40, physical address width of io messages
- dword_width_p, 64, io message data width
- lce_id_width_p, 4, LCE id width used to size the io message
- cfg_addr_width_p, 16, local cfg register address width (addr field of bp_local_addr_s)
- cce_id_width_p, 4, width of the cce field in bp_local_addr_s
- inst_ram_addr_width_p, 8, microcode RAM address width
- inst_width_p, 48, microcode instruction width
- vaddr_width_p, 39, NPC register width

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- cce_id_i  in  cce_id_width_p  this tile's id; compared against the cce field of the address
- io_cmd_i  in  cce_io_msg_width_lp  bp_cce_io_msg_s command
- io_cmd_v_i  in  1  command valid
- io_cmd_yumi_o  out  1  command consumed this cycle
- io_resp_o  out  cce_io_msg_width_lp  bp_cce_io_msg_s response
- io_resp_v_o  out  1  response valid
- io_resp_ready_i  in  1  response accepted when high with io_resp_v_o
- reset_o, freeze_o  out  1 each  tile reset / freeze
- icache_mode_o, dcache_mode_o, cce_mode_o  out  1 each  0 = uncached, 1 = normal
- npc_o  out  vaddr_width_p  next PC
- npc_w_v_o  out  1  one-cycle pulse when NPC is written
- ucode_w_v_o, ucode_r_v_o  out  1 each  microcode RAM write / read strobe
- ucode_addr_o  out  inst_ram_addr_width_p  microcode RAM address
- ucode_data_o  out  inst_width_p  microcode RAM write data
- ucode_data_i  in  inst_width_p  microcode RAM read data, valid one cycle after ucode_r_v_o

Behaviour:
- Reset (reset_n_i low at a clock edge):
  - State goes to READY; any pending response is dropped.
  - reset_o=1, freeze_o=1, all mode outputs=0, npc_o=0.
  - All strobes and io_resp_v_o are 0.
- Address decode (bp_local_addr_s):
  - hit = ~nonlocal & (cce == cce_id_i) & (dev == cfg_dev_gp).
  - Register targets match cfg addr exactly against bp_cfg_reg_{reset,freeze,icache_mode,dcache_mode,cce_mode,npc}_gp.
  - Ucode target: addr[cfg_addr_width_p-1:inst_ram_addr_width_p] equals the corresponding upper bits of bp_cfg_mem_base_cce_ucode_gp. RAM offset = addr[inst_ram_addr_width_p-1:0].
- FSM states:
  - READY: io_cmd_yumi_o = io_cmd_v_i. On accept:
    - Register write: commits at that same clock edge.
    - Ucode write: ucode_w_v_o is asserted combinationally in the accept cycle.
    - Ucode read: ucode_r_v_o is asserted in the accept cycle, then go to UCODE_WAIT.
    - Anything else: go to RESP.
  - UCODE_WAIT: capture ucode_data_i, zero-extended to dword_width_p, into the response data; go to RESP.
  - RESP: io_resp_v_o=1 and io_cmd_yumi_o=0. When io_resp_ready_i=1, return to READY.
- Latency and throughput:
  - Response valid 1 cycle after accept, or 2 cycles for ucode reads.
  - Maximum throughput is one command per 2 cycles.
- Response contents:
  - msg_type, addr, payload and size are copied from the command.
  - data = read value for reads; 0 for writes.
  - io_resp_o is stable while io_resp_v_o=1 and ready=0.
- Write width rules:
  - 1-bit registers take data[0].
  - NPC takes data[vaddr_width_p-1:0].
  - Ucode takes data[inst_width_p-1:0].
- Read values: 1-bit registers are zero-extended; NPC is zero-extended.
- Size field: any value is treated as 64-bit.
- Miss or unmapped address: the command is still consumed. Writes are ignored; reads return 0. The endpoint never stalls.
- Simultaneous events: io_cmd_v_i is ignored outside READY. Reset overrides all other inputs.

Decomposition:
- Shared package bp_common_cfg_link_pkg: bp_cfg_reg_*_gp, bp_cfg_mem_base_cce_ucode_gp, cfg_dev_gp, bp_local_addr_s.
- bp_common_pkg: e_lce_mode_*, e_cce_mode_*, e_cce_io_wr/rd, e_io_size_8.
- Package local to the module: the FSM state enum.
- Submodule bp_cce_mmio_cfg_reg_file: holds the config registers and the read mux. Register storage uses bsg_dff_reset_en.

Test Plan:
- Reset release, then no commands: reset_o=1, freeze_o=1, modes=0, npc_o=0, io_resp_v_o=0.
- Write reset=0, then write freeze=0, cce=cce_id_i: both outputs go to 0 at the accept edge; each command gets a write response with data=0 one cycle later.
- Write npc=0x00_8000_0000, then read npc: npc_w_v_o pulses once; the read response data=0x80000000.
- Ucode write offset 5, data 0x0000_1234_5678_9ABC, then ucode read offset 5 with the RAM model returning that data: ucode_w_v_o asserts with addr 5; the read response arrives 2 cycles after accept with data=0x123456789ABC.
- Hold io_resp_ready_i=0 for 10 cycles with io_cmd_v_i=1: io_cmd_yumi_o stays 0 and io_resp_o is stable. Then raise ready: the response is accepted and the next command is consumed the following cycle.
- Command with cce≠cce_id_i writing icache_mode=1: no register change, write response still returned. A read to unmapped addr 0x0FFF returns data 0. Asserting reset in RESP drops io_resp_v_o the next cycle.
